// File: rtl/shift_sequencer.sv
// shift_sequencer: accepts a word over valid/ready, applies one zero-fill
// single-bit shift per clock until the requested amount is used up, then
// presents the result over a second valid/ready handshake.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] cnt_q;
  logic             dir_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] data_d;

  // One zero-fill step in the captured direction (1 = toward LSB).
  assign data_d = dir_q ? {1'b0, data_q[WIDTH-1:1]}
                        : {data_q[WIDTH-2:0], 1'b0};

  // Handshake state and the shifting word; outputs are registered alongside.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            cnt_q      <= in_amt;
            dir_q      <= in_dir;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (in_amt == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= data_d;
          cnt_q  <= cnt_q - 1'b1;
          // Last step happens on this edge, so the result is ready next cycle.
          if (cnt_q == AMT_W'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            data_q      <= '0;
            dir_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          data_q      <= '0;
          cnt_q       <= '0;
          dir_q       <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  // Word is only exposed while a result is offered; zero otherwise.
  assign out_data  = out_valid_q ? data_q : '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed table, hand-written
// corner sequences and randomized requests against a behavioural model.
module tb_shift_sequencer;
  localparam int WIDTH = 4;
  localparam int AMT_W = 2;

  logic             clk = 1'b0;
  logic             nrst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               amt;
    logic             dir;
    int               hold;
    logic [WIDTH-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: amt zero-fill shifts equal one multi-bit logical shift.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d,
                                             input int amt, input logic dir);
    int unsigned w;
    w = d;
    if (dir) w = w >> amt;
    else     w = (w << amt) & ((1 << WIDTH) - 1);
    return w[WIDTH-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the result, apply hold cycles of backpressure,
  // complete the handshake and check the return to idle.
  task automatic do_req(input logic [WIDTH-1:0] d, input int amt,
                        input logic dir, input int hold,
                        input logic [WIDTH-1:0] exp, input string tag);
    int n;
    int busy_cnt;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk({tag, " in_ready before request"}, int'(in_ready), 1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = AMT_W'(amt);
    in_dir    = dir;
    out_ready = 1'b0;
    step();
    // Inputs change after acceptance; none of it may matter.
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    in_amt   = AMT_W'($urandom);
    in_dir   = 1'($urandom);
    n = 0;
    busy_cnt = 0;
    while (!out_valid && n < 20) begin
      if (!busy || in_ready) begin
        chk({tag, " busy/in_ready in shift"}, {busy, in_ready}, 2);
      end
      busy_cnt++;
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      step();
      n++;
    end
    chk({tag, " latency"}, n, amt);
    for (int h = 0; h <= hold; h++) begin
      chk({tag, " out_valid"}, int'(out_valid), 1);
      chk({tag, " out_data"}, int'(out_data), int'(exp));
      chk({tag, " in_ready in done"}, int'(in_ready), 0);
      if (busy) busy_cnt++;
      if (h < hold) begin
        out_ready = 1'b0;
        in_valid  = 1'($urandom);
        in_data   = WIDTH'($urandom);
      end else begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      step();
    end
    out_ready = 1'b0;
    chk({tag, " busy cycles"}, busy_cnt, amt + 1 + hold);
    chk({tag, " idle after handshake"},
        {out_valid, busy, in_ready, out_data}, {1'b0, 1'b0, 1'b1, {WIDTH{1'b0}}});
  endtask

  vec_t tbl[$];

  initial begin
    nrst      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_dir    = 1'b0;
    out_ready = 1'b0;

    tbl.push_back('{4'b0011, 1, 1'b0, 0, 4'b0110});
    tbl.push_back('{4'b1011, 3, 1'b1, 0, 4'b0001});
    tbl.push_back('{4'b1001, 0, 1'b0, 0, 4'b1001});
    tbl.push_back('{4'b0001, 2, 1'b0, 5, 4'b0100});
    tbl.push_back('{4'b1111, 3, 1'b0, 0, 4'b1000});
    tbl.push_back('{4'b1111, 3, 1'b1, 0, 4'b0001});
    tbl.push_back('{4'b1000, 1, 1'b0, 1, 4'b0000});
    tbl.push_back('{4'b0001, 1, 1'b1, 2, 4'b0000});

    #12;
    chk("reset outputs", {out_valid, busy, in_ready, out_data},
        {1'b0, 1'b0, 1'b1, {WIDTH{1'b0}}});
    nrst = 1'b1;
    step();

    foreach (tbl[i])
      do_req(tbl[i].data, tbl[i].amt, tbl[i].dir, tbl[i].hold, tbl[i].exp,
             $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a 3-step shift.
    in_valid = 1'b1; in_data = 4'b1110; in_amt = 2'd3; in_dir = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    chk("mid-shift busy", int'(busy), 1);
    #2 nrst = 1'b0;
    #1;
    chk("async reset outputs", {out_valid, busy, in_ready, out_data},
        {1'b0, 1'b0, 1'b1, {WIDTH{1'b0}}});
    #3 nrst = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      chk("no output after reset", int'(out_valid), 0);
      step();
    end
    do_req(4'b0101, 1, 1'b1, 0, 4'b0010, "post-reset");

    // Randomized requests checked against the model.
    for (int r = 0; r < 40; r++) begin
      logic [WIDTH-1:0] d;
      int a, h;
      logic dr;
      d  = WIDTH'($urandom);
      a  = $urandom_range(0, (1 << AMT_W) - 1);
      dr = 1'($urandom);
      h  = $urandom_range(0, 3);
      do_req(d, a, dr, h, model(d, a, dr), $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
